trig_frame_packer: RTL and testbench
====================================

# trig_frame_packer

Parametrised, multi-channel successor to the fixed-format header/footer inserter in the minimum-trigger path. It wraps each contiguous run of triggered ADC words in a header word and a footer word. It adds a runtime channel ID, bridging of one-cycle trigger dropouts, gating on DIN_VALID, a frame word count in the footer and optional truncation of long frames. It sits between the trigger/baseline logic and the packet FIFO, and produces one continuous output stream with no backpressure.

## Interface
- DATA_WIDTH, 128: sample/output word width, ≥128.
- TIME_STAMP_WIDTH, 49: timestamp width; TIME_STAMP_WIDTH−FIRST_TIME_STAMP_WIDTH must equal 23.
- FIRST_TIME_STAMP_WIDTH, 26: upper timestamp bits carried in the header.
- ADC_RESOLUTION_WIDTH, 12: baseline width; the threshold is ADC_RESOLUTION_WIDTH+1 bits.
- CH_ID_WIDTH, 4: channel ID width, ≤8, zero-extended to 8 in the header.
- MAX_FRAME_WORDS, 256: data-word limit per frame, 1..32767; used only with FRAME_TRUNCATE_EN.
- CLK  in  1  sole clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- DIN_VALID  in  1  DIN carries a real sample.
- TRIGGERED  in  1  trigger level from the discriminator.
- CH_ID  in  CH_ID_WIDTH  channel ID, latched at frame start.
- TIME_STAMP  in  TIME_STAMP_WIDTH  free-running timestamp.
- THRESHOLD_WHEN_HIT  in  ADC_RESOLUTION_WIDTH+1  threshold, latched at frame start.
- BASELINE_WHEN_HIT  in  ADC_RESOLUTION_WIDTH  baseline, latched at frame start.
- DIN  in  DATA_WIDTH  ADC word.
- DOUT  out  DATA_WIDTH  framed stream.
- DOUT_VALID  out  1  DOUT holds a header, footer or counted data word.
- DOUT_HEADER  out  1  DOUT is a header word.
- DOUT_FOOTER  out  1  DOUT is a footer word.

## Operation
- State machine states: IDLE, DATA, DISCARD.
- Cycle t is the first cycle with TRIGGERED sampled high while in IDLE (previous sample low). At t the block latches CH_ID, the upper FIRST_TIME_STAMP_WIDTH bits of TIME_STAMP, the threshold and the baseline.
- Header word: {all ones [DATA_WIDTH-1:64], 8'hFF, ch_id zero-extended to 8, TS_hi (26 bits), 22'h0}.
- Footer word: {4'hF, baseline, 3'h7, threshold, 1'b0, TS_lo (23 bits), 8'h0F, all ones [DATA_WIDTH-65:16], trunc (1 bit), count (15 bits)}.
  - TS_lo is TIME_STAMP[22:0] of the last data sample in the frame.
- Data words pass through unchanged. DOUT_VALID is high only when the sample's DIN_VALID was high. Only these words are counted.
- Frame close: TRIGGERED is low for ≥2 consecutive samples. The frame closes after the last high sample.
- Dropout bridging: a single low sample with high samples on both sides is bridged. The frame stays open, the low sample is emitted as data, and it is counted if its DIN_VALID is high.
- Transitions:
  - IDLE→DATA on a rising edge.
  - DATA→IDLE on close; the footer is emitted.
  - DATA→DISCARD on truncation (FRAME_TRUNCATE_EN only).
  - DISCARD→IDLE once TRIGGERED is sampled low.
- The 15-bit count saturates at 32767.
- Outside frames: DOUT = DIN delayed 2 cycles, with DOUT_VALID, DOUT_HEADER and DOUT_FOOTER all low.
- RESET mid-frame aborts the frame; no footer is emitted.

## Timing
- Reset values: DOUT all ones, DOUT_VALID 0, DOUT_HEADER 0, DOUT_FOOTER 0, state IDLE, count 0.
- Data latency is 2 cycles: a sample entering at cycle n appears on DOUT at n+2.
- Header appears at t+1.
- For a last high sample e followed by two low samples: the data for e appears at e+2 and the footer at e+3.
  - The footer replaces the delayed e+1 sample.
- Footer and header can never coincide. A new rising edge at r ≥ e+3 puts its header at r+1 ≥ e+4. A rise at e+2 is bridged instead.
- DOUT_HEADER and DOUT_FOOTER are never high together. Each is high for exactly 1 cycle per frame.

## Configuration
- FRAME_TRUNCATE_EN defined:
  - When the counted data word number MAX_FRAME_WORDS is accepted at sample s, its data appears at s+2 and the footer at s+3, with trunc=1 and count=MAX_FRAME_WORDS.
  - Samples from s+1 onward are discarded: DOUT_VALID is low.
  - DISCARD waits for TRIGGERED low. A rising edge at s+2 is ignored; that trigger period is dropped.
- FRAME_TRUNCATE_EN undefined: no limit, trunc is always 0, the DISCARD state is absent and MAX_FRAME_WORDS is unused.

## Test plan
- TRIGGERED high cycles 10–14, DIN_VALID=1, CH_ID=4'h3 -> header at 11 with bits[55:48]=8'h03, data 12–16, footer at 17 with count=5 and trunc=0.
- TRIGGERED high cycles 10–12 and 14–15 (one-cycle low at 13) -> one header at 11, 6 data words 12–17, footer at 18 with count=6.
- TRIGGERED high cycles 10–14 with DIN_VALID=0 at 12 -> DOUT_VALID low at 14, footer count=4.
- FRAME_TRUNCATE_EN, MAX_FRAME_WORDS=4, TRIGGERED high cycles 10–20 -> data 12–15, footer at 16 with trunc=1 and count=4, DOUT_VALID low 17–22, no new header.
- RESET at cycle 13 of a frame starting at 10 -> from 14 on: DOUT all ones, all flags 0, no footer.
- TIME_STAMP=49'h1_2345_6789_ABCD at cycle 10 (frame start) and TIME_STAMP of the last sample = n -> header bits[47:22] = TIME_STAMP[48:23] at cycle 10, footer TS_lo = n[22:0].

Source files
------------

// File: rtl/trig_frame_packer.sv
// trig_frame_packer: wraps contiguous triggered ADC runs in header/footer words.
// Optional macro FRAME_TRUNCATE_EN caps each frame at MAX_FRAME_WORDS counted words.
module trig_frame_packer #(
  parameter int unsigned DATA_WIDTH             = 128,
  parameter int unsigned TIME_STAMP_WIDTH       = 49,
  parameter int unsigned FIRST_TIME_STAMP_WIDTH = 26,
  parameter int unsigned ADC_RESOLUTION_WIDTH   = 12,
  parameter int unsigned CH_ID_WIDTH            = 4,
  parameter int unsigned MAX_FRAME_WORDS        = 256
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            DIN_VALID,
  input  logic                            TRIGGERED,
  input  logic [CH_ID_WIDTH-1:0]          CH_ID,
  input  logic [TIME_STAMP_WIDTH-1:0]     TIME_STAMP,
  input  logic [ADC_RESOLUTION_WIDTH:0]   THRESHOLD_WHEN_HIT,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE_WHEN_HIT,
  input  logic [DATA_WIDTH-1:0]           DIN,
  output logic [DATA_WIDTH-1:0]           DOUT,
  output logic                            DOUT_VALID,
  output logic                            DOUT_HEADER,
  output logic                            DOUT_FOOTER
);

  localparam int unsigned TS_LO_W    = 23;
  localparam int unsigned THR_W      = ADC_RESOLUTION_WIDTH + 1;
  localparam int unsigned CNT_W      = 15;
  localparam int unsigned HDR_FILL_W = DATA_WIDTH - FIRST_TIME_STAMP_WIDTH - 38;
  localparam int unsigned FTR_FILL_W = DATA_WIDTH - 2 * ADC_RESOLUTION_WIDTH - 56;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef FRAME_TRUNCATE_EN
  typedef enum logic [1:0] {IDLE, DATA, DISCARD} state_t;
`else
  typedef enum logic {IDLE, DATA} state_t;
  localparam int unsigned max_words_unused = MAX_FRAME_WORDS;
`endif

  state_t state_q, state_d;

  // one-sample delay stage; lets the close/bridge decision see the next sample
  logic [DATA_WIDTH-1:0]           s1_din;
  logic                            s1_valid;
  logic                            s1_trig;
  logic [TS_LO_W-1:0]              s1_ts_lo;

  logic [ADC_RESOLUTION_WIDTH-1:0] base_q;
  logic [THR_W-1:0]                thr_q;
  logic [TS_LO_W-1:0]              ts_lo_q, ts_lo_d;
  logic [CNT_W-1:0]                count_q, count_d;
  logic                            trunc_q, trunc_d;

  logic [DATA_WIDTH-1:0]           dout_d;
  logic                            valid_d, hdr_d, ftr_d, latch_d;

  logic                            rise_c, close_c, take_c, limit_c;
  logic [CNT_W-1:0]                cnt_inc_c;
  logic [DATA_WIDTH-1:0]           header_c, footer_c;

  assign rise_c    = TRIGGERED && !s1_trig;
  assign close_c   = !s1_trig && !TRIGGERED;
  assign take_c    = (state_q == DATA) && !close_c;
  assign cnt_inc_c = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);

`ifdef FRAME_TRUNCATE_EN
  assign limit_c = take_c && s1_valid &&
                   ((32'(count_q) + 32'd1) == 32'(MAX_FRAME_WORDS));
`else
  assign limit_c = 1'b0;
`endif

  assign header_c = {{HDR_FILL_W{1'b1}}, 8'hFF, 8'(CH_ID),
                     TIME_STAMP[TIME_STAMP_WIDTH-1 -: FIRST_TIME_STAMP_WIDTH], 22'h0};

  assign footer_c = {4'hF, base_q, 3'h7, thr_q, 1'b0, ts_lo_q, 8'h0F,
                     {FTR_FILL_W{1'b1}}, trunc_q, count_q};

  // state register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rise_c) state_d = DATA;
      DATA: begin
        if (limit_c)      state_d = state_t'(2);
        else if (close_c) state_d = IDLE;
      end
`ifdef FRAME_TRUNCATE_EN
      DISCARD: if (!TRIGGERED) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // output / datapath next values
  always_comb begin
    dout_d  = s1_din;
    valid_d = 1'b0;
    hdr_d   = 1'b0;
    ftr_d   = 1'b0;
    latch_d = 1'b0;
    count_d = count_q;
    ts_lo_d = ts_lo_q;
    trunc_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_c) begin
          dout_d  = header_c;
          valid_d = 1'b1;
          hdr_d   = 1'b1;
          latch_d = 1'b1;
          count_d = '0;
          ts_lo_d = '0;
        end
      end
      DATA: begin
        if (close_c) begin
          dout_d  = footer_c;
          valid_d = 1'b1;
          ftr_d   = 1'b1;
        end else begin
          valid_d = s1_valid;
          ts_lo_d = s1_ts_lo;
          if (s1_valid) count_d = cnt_inc_c;
          trunc_d = limit_c;
        end
      end
      default: begin
        // first DISCARD cycle carries the truncated-frame footer
        if (trunc_q) begin
          dout_d  = footer_c;
          valid_d = 1'b1;
          ftr_d   = 1'b1;
        end
      end
    endcase
  end

  // datapath and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_din      <= '1;
      s1_valid    <= 1'b0;
      s1_trig     <= 1'b0;
      s1_ts_lo    <= '0;
      base_q      <= '0;
      thr_q       <= '0;
      ts_lo_q     <= '0;
      count_q     <= '0;
      trunc_q     <= 1'b0;
      DOUT        <= '1;
      DOUT_VALID  <= 1'b0;
      DOUT_HEADER <= 1'b0;
      DOUT_FOOTER <= 1'b0;
    end else begin
      s1_din      <= DIN;
      s1_valid    <= DIN_VALID;
      s1_trig     <= TRIGGERED;
      s1_ts_lo    <= TIME_STAMP[TS_LO_W-1:0];
      if (latch_d) begin
        base_q <= BASELINE_WHEN_HIT;
        thr_q  <= THRESHOLD_WHEN_HIT;
      end
      ts_lo_q     <= ts_lo_d;
      count_q     <= count_d;
      trunc_q     <= trunc_d;
      DOUT        <= dout_d;
      DOUT_VALID  <= valid_d;
      DOUT_HEADER <= hdr_d;
      DOUT_FOOTER <= ftr_d;
    end
  end

endmodule

// File: tb/tb_trig_frame_packer.sv
// tb_trig_frame_packer: directed frames with a queued scoreboard and output monitor.
module tb_trig_frame_packer;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         DIN_VALID;
  logic         TRIGGERED;
  logic [3:0]   CH_ID;
  logic [48:0]  TIME_STAMP;
  logic [12:0]  THRESHOLD_WHEN_HIT;
  logic [11:0]  BASELINE_WHEN_HIT;
  logic [127:0] DIN;
  logic [127:0] DOUT;
  logic         DOUT_VALID;
  logic         DOUT_HEADER;
  logic         DOUT_FOOTER;

  typedef struct {
    int           cyc;
    logic         hdr;
    logic         ftr;
    logic [127:0] dout;
  } exp_t;

  exp_t exp_q[$];
  int   n_run  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   tid    = 0;

  trig_frame_packer #(.MAX_FRAME_WORDS(4)) dut (
    .CLK(CLK), .RESET(RESET), .DIN_VALID(DIN_VALID), .TRIGGERED(TRIGGERED),
    .CH_ID(CH_ID), .TIME_STAMP(TIME_STAMP), .THRESHOLD_WHEN_HIT(THRESHOLD_WHEN_HIT),
    .BASELINE_WHEN_HIT(BASELINE_WHEN_HIT), .DIN(DIN), .DOUT(DOUT),
    .DOUT_VALID(DOUT_VALID), .DOUT_HEADER(DOUT_HEADER), .DOUT_FOOTER(DOUT_FOOTER)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(string nm, logic [191:0] got, logic [191:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s test=%0d cyc=%0d got=%h required=%h", nm, tid, cyc, got, exp);
    end
  endfunction

  function automatic logic [48:0] ts_of(int c);
    return 49'h1_2345_6789_ABCD + 49'(c) - 49'd10;
  endfunction

  function automatic logic [127:0] din_of(int c);
    return {16'hDA7A, 8'(tid), 96'h0, 8'(c)};
  endfunction

  function automatic logic [127:0] hdr_w(logic [3:0] ch, int c);
    logic [48:0] t = ts_of(c);
    return {64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4'h0, ch, t[48:23], 22'h0};
  endfunction

  function automatic logic [127:0] ftr_w(logic [11:0] b, logic [12:0] th, int c,
                                         logic tr, logic [14:0] n);
    logic [48:0] t = ts_of(c);
    return {4'hF, b, 3'h7, th, 1'b0, t[22:0], 8'h0F, 48'hFFFF_FFFF_FFFF, tr, n};
  endfunction

  function automatic logic trig_of(int t, int c);
    case (t)
      2:       return (c >= 10 && c <= 12) || c == 14 || c == 15;
      4:       return c >= 10 && c <= 20;
      5:       return (c >= 10 && c <= 14) || c == 17;
      6:       return c >= 10 && c <= 13;
      default: return c >= 10 && c <= 14;
    endcase
  endfunction

  task automatic push(int c, logic h, logic f, logic [127:0] d);
    exp_t e;
    e.cyc = c; e.hdr = h; e.ftr = f; e.dout = d;
    exp_q.push_back(e);
  endtask

  task automatic load_expect(int t);
    push(11, 1'b1, 1'b0, hdr_w(4'h3, 10));
    case (t)
      2: begin
        for (int k = 10; k <= 15; k++) push(k + 2, 1'b0, 1'b0, din_of(k));
        push(18, 1'b0, 1'b1, ftr_w(12'h123, 13'h0ABC, 15, 1'b0, 15'd6));
      end
      3: begin
        for (int k = 10; k <= 14; k++)
          if (k != 12) push(k + 2, 1'b0, 1'b0, din_of(k));
        push(17, 1'b0, 1'b1, ftr_w(12'h123, 13'h0ABC, 14, 1'b0, 15'd4));
      end
      4: begin
`ifdef FRAME_TRUNCATE_EN
        for (int k = 10; k <= 13; k++) push(k + 2, 1'b0, 1'b0, din_of(k));
        push(16, 1'b0, 1'b1, ftr_w(12'h123, 13'h0ABC, 13, 1'b1, 15'd4));
`else
        for (int k = 10; k <= 20; k++) push(k + 2, 1'b0, 1'b0, din_of(k));
        push(23, 1'b0, 1'b1, ftr_w(12'h123, 13'h0ABC, 20, 1'b0, 15'd11));
`endif
      end
      6: begin
        push(12, 1'b0, 1'b0, din_of(10));
        push(13, 1'b0, 1'b0, din_of(11));
      end
      default: begin
        for (int k = 10; k <= 14; k++) push(k + 2, 1'b0, 1'b0, din_of(k));
        push(17, 1'b0, 1'b1, ftr_w(12'h123, 13'h0ABC, 14, 1'b0, 15'd5));
        if (t == 5) begin
          push(18, 1'b1, 1'b0, hdr_w(4'hC, 17));
          push(19, 1'b0, 1'b0, din_of(17));
          push(20, 1'b0, 1'b1, ftr_w(12'h456, 13'h1555, 17, 1'b0, 15'd1));
        end
      end
    endcase
  endtask

  task automatic drive(int t, int c);
    RESET              = (c < 2) || (t == 6 && c == 13);
    TRIGGERED          = trig_of(t, c);
    DIN_VALID          = !(t == 3 && c == 12);
    CH_ID              = (c <= 10) ? 4'h3 : 4'hC;
    BASELINE_WHEN_HIT  = (c <= 10) ? 12'h123 : 12'h456;
    THRESHOLD_WHEN_HIT = (c <= 10) ? 13'h0ABC : 13'h1555;
    TIME_STAMP         = ts_of(c);
    DIN                = din_of(c);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (DOUT_VALID || DOUT_HEADER || DOUT_FOOTER) begin
        if (exp_q.size() == 0) begin
          n_run++;
          n_fail++;
          $display("FAIL unexpected_out test=%0d cyc=%0d got dout=%h v/h/f=%b%b%b required no output",
                   tid, cyc, DOUT, DOUT_VALID, DOUT_HEADER, DOUT_FOOTER);
        end else begin
          e = exp_q.pop_front();
          chk("out_cycle", 192'(cyc), 192'(e.cyc));
          chk("out_flags", 192'({DOUT_VALID, DOUT_HEADER, DOUT_FOOTER}),
              192'({1'b1, e.hdr, e.ftr}));
          chk("out_dout", 192'(DOUT), 192'(e.dout));
        end
      end
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    drive(0, 0);
    @(posedge CLK); #1;
    for (int t = 1; t <= 6; t++) begin
      tid = t;
      exp_q.delete();
      load_expect(t);
      for (int c = 0; c < 30; c++) begin
        cyc = c;
        drive(t, c);
        if (c == 2) begin
          chk("reset_dout", 192'(DOUT), 192'({128{1'b1}}));
          chk("reset_flags", 192'({DOUT_VALID, DOUT_HEADER, DOUT_FOOTER}), 192'(0));
        end
        if (c == 9) begin
          chk("passthru_dout", 192'(DOUT), 192'(din_of(7)));
          chk("passthru_flags", 192'({DOUT_VALID, DOUT_HEADER, DOUT_FOOTER}), 192'(0));
        end
        if (t == 3 && c == 14) begin
          chk("invalid_word_valid", 192'(DOUT_VALID), 192'(0));
          chk("invalid_word_dout", 192'(DOUT), 192'(din_of(12)));
        end
`ifdef FRAME_TRUNCATE_EN
        if (t == 4 && c >= 17 && c <= 22)
          chk("discard_valid", 192'(DOUT_VALID), 192'(0));
`endif
        if (t == 6 && (c == 14 || c == 15)) begin
          chk("abort_dout", 192'(DOUT), 192'({128{1'b1}}));
          chk("abort_flags", 192'({DOUT_VALID, DOUT_HEADER, DOUT_FOOTER}), 192'(0));
        end
        @(posedge CLK); #1;
      end
      chk("missing_out", 192'(exp_q.size()), 192'(0));
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
